// File: rtl/vga_sync_timing_generator.sv
// vga_sync_timing_generator: nested pixel/line counters with decode of syncs, display enable, coordinates and strobes.
// Latency: outputs are a zero-latency decode of the registered counters; the first cycle after reset is position (0,0).
// Backpressure: none; with VGA_PIXEL_CE_EN defined, pixel_ce gates counter advance and the strobes.
module vga_sync_timing_generator #(
  parameter int COUNTER_WIDTH = 11,
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0
) (
  input  logic                     control_clock,
  input  logic                     reset,
`ifdef VGA_PIXEL_CE_EN
  input  logic                     pixel_ce,
`endif
  output logic                     h_sync,
  output logic                     v_sync,
  output logic                     display_enable,
  output logic [COUNTER_WIDTH-1:0] pixel_x,
  output logic [COUNTER_WIDTH-1:0] pixel_y,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Wrap points fit the counter width once the totals pass the elaboration check below.
  localparam logic [COUNTER_WIDTH-1:0] H_LAST = COUNTER_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_LAST = COUNTER_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE    = COUNTER_WIDTH'(1);

  // Region bounds carry one extra bit so an end bound equal to 2**COUNTER_WIDTH is still representable.
  localparam logic [COUNTER_WIDTH:0] H_ACT_END  = (COUNTER_WIDTH+1)'(H_ACTIVE);
  localparam logic [COUNTER_WIDTH:0] H_SYNC_BEG = (COUNTER_WIDTH+1)'(H_ACTIVE + H_FRONT);
  localparam logic [COUNTER_WIDTH:0] H_SYNC_END = (COUNTER_WIDTH+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COUNTER_WIDTH:0] V_ACT_END  = (COUNTER_WIDTH+1)'(V_ACTIVE);
  localparam logic [COUNTER_WIDTH:0] V_SYNC_BEG = (COUNTER_WIDTH+1)'(V_ACTIVE + V_FRONT);
  localparam logic [COUNTER_WIDTH:0] V_SYNC_END = (COUNTER_WIDTH+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic H_POL = (H_SYNC_POL != 0);
  localparam logic V_POL = (V_SYNC_POL != 0);

  if (H_TOTAL < 1 || H_TOTAL > (1 << COUNTER_WIDTH)) begin : g_h_total_check
    $error("vga_sync_timing_generator: H_TOTAL=%0d does not fit COUNTER_WIDTH=%0d", H_TOTAL, COUNTER_WIDTH);
  end
  if (V_TOTAL < 1 || V_TOTAL > (1 << COUNTER_WIDTH)) begin : g_v_total_check
    $error("vga_sync_timing_generator: V_TOTAL=%0d does not fit COUNTER_WIDTH=%0d", V_TOTAL, COUNTER_WIDTH);
  end

  logic                     advance;
  logic [COUNTER_WIDTH-1:0] h_count;
  logic [COUNTER_WIDTH-1:0] v_count;
  logic [COUNTER_WIDTH:0]   h_ext;
  logic [COUNTER_WIDTH:0]   v_ext;
  logic                     h_in_active;
  logic                     v_in_active;
  logic                     h_sync_act;
  logic                     v_sync_act;
  logic                     de;

`ifdef VGA_PIXEL_CE_EN
  assign advance = pixel_ce;
`else
  assign advance = 1'b1;
`endif

  // Pixel counter wraps at end of line; the line counter steps (and wraps) only on that pixel wrap.
  always_ff @(posedge control_clock) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (advance) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        if (v_count == V_LAST) begin
          v_count <= '0;
        end else begin
          v_count <= v_count + ONE;
        end
      end else begin
        h_count <= h_count + ONE;
      end
    end
  end

  assign h_ext = {1'b0, h_count};
  assign v_ext = {1'b0, v_count};

  // Region decode straight off the counters so every output refers to the same screen position.
  always_comb begin
    h_in_active = (h_ext < H_ACT_END);
    v_in_active = (v_ext < V_ACT_END);
    h_sync_act  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    v_sync_act  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    de          = h_in_active && v_in_active;
  end

  // Output drive; reset forces everything inactive in the same cycle so no partial pulse leaks out.
  always_comb begin
    h_sync         = ~H_POL;
    v_sync         = ~V_POL;
    display_enable = 1'b0;
    pixel_x        = '0;
    pixel_y        = '0;
    line_start     = 1'b0;
    frame_start    = 1'b0;
    if (!reset) begin
      h_sync         = h_sync_act ? H_POL : ~H_POL;
      v_sync         = v_sync_act ? V_POL : ~V_POL;
      display_enable = de;
      pixel_x        = de ? h_count : '0;
      pixel_y        = de ? v_count : '0;
      line_start     = advance && (h_count == '0);
      frame_start    = advance && (h_count == '0) && (v_count == '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_timing_generator.sv
// Directed bench: default 640x480 instance checked at line level, small-parameter instance at frame level.
// Table of hand-computed vectors for the small instance, then reference-model sweeps and reset/clock-enable sequences.
// Clock-enable sequence is compiled in only when VGA_PIXEL_CE_EN is defined.
module tb_vga_sync_timing_generator;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] px;
    logic [3:0] py;
    logic       ls;
    logic       fs;
  } small_o_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] px;
    logic [10:0] py;
    logic        ls;
    logic        fs;
  } big_o_t;

  typedef struct {
    int       cyc;
    small_o_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef VGA_PIXEL_CE_EN
  logic pce = 1'b1;
`endif

  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [10:0] b_px, b_py;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0]  s_px, s_py;

  big_o_t   big_act;
  small_o_t small_act;
  assign big_act   = {b_hs, b_vs, b_de, b_px, b_py, b_ls, b_fs};
  assign small_act = {s_hs, s_vs, s_de, s_px, s_py, s_ls, s_fs};

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  always #5 clk = ~clk;

  vga_sync_timing_generator dut_big (
    .control_clock (clk),
    .reset         (rst),
`ifdef VGA_PIXEL_CE_EN
    .pixel_ce      (pce),
`endif
    .h_sync        (b_hs),
    .v_sync        (b_vs),
    .display_enable(b_de),
    .pixel_x       (b_px),
    .pixel_y       (b_py),
    .line_start    (b_ls),
    .frame_start   (b_fs)
  );

  vga_sync_timing_generator #(
    .COUNTER_WIDTH(4),
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(0)
  ) dut_small (
    .control_clock (clk),
    .reset         (rst),
`ifdef VGA_PIXEL_CE_EN
    .pixel_ce      (pce),
`endif
    .h_sync        (s_hs),
    .v_sync        (s_vs),
    .display_enable(s_de),
    .pixel_x       (s_px),
    .pixel_y       (s_py),
    .line_start    (s_ls),
    .frame_start   (s_fs)
  );

  // Small timing: line 14 clocks (active 0..7, sync high 10..12), frame 7 lines, v_sync low on line 5.
  function automatic small_o_t small_model(int h, int v, bit adv);
    small_o_t o;
    o.hs = (h >= 10 && h < 13);
    o.vs = (v != 5);
    o.de = (h < 8 && v < 4);
    o.px = o.de ? 4'(h) : 4'd0;
    o.py = o.de ? 4'(v) : 4'd0;
    o.ls = adv && (h == 0);
    o.fs = adv && (h == 0) && (v == 0);
    return o;
  endfunction

  // Default 640x480 timing: h_sync low on 656..751, v_sync low on lines 490..491.
  function automatic big_o_t big_model(int h, int v, bit adv);
    big_o_t o;
    o.hs = !(h >= 656 && h < 752);
    o.vs = !(v >= 490 && v < 492);
    o.de = (h < 640 && v < 480);
    o.px = o.de ? 11'(h) : 11'd0;
    o.py = o.de ? 11'(v) : 11'd0;
    o.ls = adv && (h == 0);
    o.fs = adv && (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic vec_t mk(int c, bit hs, bit vs, bit de, int px, int py, bit ls, bit fs);
    vec_t r;
    r.cyc    = c;
    r.exp.hs = hs;
    r.exp.vs = vs;
    r.exp.de = de;
    r.exp.px = 4'(px);
    r.exp.py = 4'(py);
    r.exp.ls = ls;
    r.exp.fs = fs;
    return r;
  endfunction

  task automatic chk_small(input string name, input small_o_t exp);
    n_tests++;
    if (small_act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %b required %b (hs vs de px py ls fs)", name, cur, small_act, exp);
    end
  endtask

  task automatic chk_big(input string name, input big_o_t exp);
    n_tests++;
    if (big_act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %b required %b (hs vs de px py ls fs)", name, cur, big_act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cur++;
    @(negedge clk);
  endtask

  vec_t     vecs[14];
  big_o_t   big_rst;
  small_o_t small_rst;
  int       hs_low;
  int       ls_cnt;

  initial begin
    //                 cyc hs vs de px py ls fs
    vecs[0]  = mk(  0, 0, 1, 1, 0, 0, 1, 1);
    vecs[1]  = mk(  7, 0, 1, 1, 7, 0, 0, 0);
    vecs[2]  = mk(  8, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk( 10, 1, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk( 12, 1, 1, 0, 0, 0, 0, 0);
    vecs[5]  = mk( 13, 0, 1, 0, 0, 0, 0, 0);
    vecs[6]  = mk( 14, 0, 1, 1, 0, 1, 1, 0);
    vecs[7]  = mk( 47, 0, 1, 1, 5, 3, 0, 0);
    vecs[8]  = mk( 56, 0, 1, 0, 0, 0, 1, 0);
    vecs[9]  = mk( 70, 0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk( 83, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk( 84, 0, 1, 0, 0, 0, 1, 0);
    vecs[12] = mk( 98, 0, 1, 1, 0, 0, 1, 1);
    vecs[13] = mk(108, 1, 1, 0, 0, 0, 0, 0);

    big_rst      = '0;
    big_rst.hs   = 1'b1;
    big_rst.vs   = 1'b1;
    small_rst    = '0;
    small_rst.vs = 1'b1;

    // Reset held for three edges: every output inactive.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_big("reset_big", big_rst);
    chk_small("reset_small", small_rst);

    // Release after a fourth reset edge; cycle 0 is position (0,0).
    @(posedge clk);
    #1 rst = 1'b0;
    cur = 0;

    // Hand-computed small-timing vectors.
    for (int i = 0; i < 14; i++) begin
      while (cur < vecs[i].cyc) begin
        @(posedge clk);
        cur++;
      end
      @(negedge clk);
      chk_small($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Two full default lines plus the start of the third against the reference models.
    hs_low = 0;
    ls_cnt = 0;
    while (cur < 1699) begin
      step();
      chk_big("line_timing", big_model(cur % 800, cur / 800, 1'b1));
      chk_small("frame_timing", small_model((cur % 98) % 14, (cur % 98) / 14, 1'b1));
      if (cur >= 800 && cur < 1600 && !b_hs) hs_low++;
      if (b_ls) ls_cnt++;
    end
    chk_int("hsync_low_width", hs_low, 96);
    chk_int("line_start_count", ls_cnt, 2);

    // Mid-frame reset for one cycle while the small instance sits at line 2, pixel 5.
    while ((cur % 98) != 32) step();
    @(posedge clk);
    cur++;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_big("midreset_big_forced", big_rst);
    chk_small("midreset_small_forced", small_rst);
    @(posedge clk);
    #1 rst = 1'b0;
    cur = 0;
    @(negedge clk);
    chk_small("midreset_small_origin", small_model(0, 0, 1'b1));
    chk_big("midreset_big_origin", big_model(0, 0, 1'b1));
    step();
    chk_small("midreset_small_next", small_model(1, 0, 1'b1));
    chk_big("midreset_big_next", big_model(1, 0, 1'b1));

`ifdef VGA_PIXEL_CE_EN
    // Clock enable toggling 1/0: timing halves in rate, strobes only on enabled cycles, reset overrides pce=0.
    @(posedge clk);
    #1 rst = 1'b1;
    pce = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    pce = 1'b1;
    cur = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(posedge clk);
        cur++;
        #1 pce = ((k % 2) == 0);
      end
      @(negedge clk);
      chk_small("ce_small", small_model((((k + 1) / 2) % 98) % 14, (((k + 1) / 2) % 98) / 14, (k % 2) == 0));
      chk_big("ce_big", big_model((k + 1) / 2, 0, (k % 2) == 0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
